alien_formation_ctrl: RTL and testbench

Owns the alien formation state that feeds Draw_VGA: the live-alien bitmap, the formation origin (AliensRow/AliensCol), the march direction, and the Reached_Bottom / Aliens_Defeated flags.
It advances the formation once every N frames, reverses and drops at the screen edges, and clears aliens on bullet hits. The march speeds up as aliens are killed.
It sits between the frame-timing logic (FrameTick), the bullet/collision logic (hit reports) and Draw_VGA.

---
 rtl/alien_formation_ctrl.sv | 251 +++++++++++++++++++++++++
 tb/tb_alien_formation_ctrl.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/alien_formation_ctrl.sv
// alien_formation_ctrl
//   Owns the alien formation state consumed by Draw_VGA. It marches the
//   formation one step every "period" frames, reverses and drops at the screen
//   edges, clears aliens on bullet hits and raises the sticky game-over /
//   wave-cleared flags. The march speeds up by one frame per four kills.
//
// Ports
//   Clk             system clock
//   Reset           synchronous, active-high reset
//   FrameTick       one-cycle pulse per video frame
//   HitValid        one-cycle pulse: an alien was hit
//   HitIndex        grid bit index (row*10 + col) of the hit alien
//   NewWave         reload the formation; honoured only once the wave is cleared
//   Aliens_Grid     live-alien bitmap, 1 = alive
//   AliensRow       formation origin row (pixels)
//   AliensCol       formation origin column (pixels, see col_s below)
//   Dir             march direction, 1 = right
//   StepPulse       one-cycle pulse aligned with a newly applied move/drop
//   Reached_Bottom  sticky game-over flag
//   Aliens_Defeated sticky wave-cleared flag
//
// state     | meaning
// ----------+-----------------------------------------------------------
// RUN       | formation marches, hits are accepted
// GAME_OVER | formation reached the player; everything frozen until Reset
// CLEARED   | every alien destroyed; frozen until NewWave starts a wave

module alien_formation_ctrl #(
  parameter int START_COL    = 20,
  parameter int START_ROW    = 40,
  parameter int STEP_X       = 8,
  parameter int DROP_Y       = 10,
  parameter int LEFT_LIMIT   = 0,
  parameter int RIGHT_LIMIT  = 640,
  parameter int BOTTOM_LIMIT = 400,
  parameter int BASE_PERIOD  = 30
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        FrameTick,
  input  logic        HitValid,
  input  logic [5:0]  HitIndex,
  input  logic        NewWave,
  output logic [49:0] Aliens_Grid,
  output logic [8:0]  AliensRow,
  output logic [9:0]  AliensCol,
  output logic        Dir,
  output logic        StepPulse,
  output logic        Reached_Bottom,
  output logic        Aliens_Defeated
);

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    GAME_OVER = 2'd1,
    CLEARED   = 2'd2
  } state_e;

  localparam logic signed [10:0] STEP_S   = 11'(STEP_X);
  localparam logic signed [10:0] RIGHT_S  = 11'(RIGHT_LIMIT);
  localparam logic signed [10:0] LEFT_S   = 11'(LEFT_LIMIT + STEP_X);
  localparam logic        [10:0] BOTTOM_U = 11'(BOTTOM_LIMIT);
  localparam logic        [7:0]  BASE_P   = 8'(BASE_PERIOD);

  state_e      state_q, state_d;
  logic [49:0] grid_q, grid_d;
  logic [8:0]  row_q, row_d;
  logic [9:0]  col_q, col_d;
  logic        dir_q, dir_d;
  logic        step_pulse_q, step_pulse_d;
  logic        bottom_q, bottom_d;
  logic        defeated_q, defeated_d;
  logic [7:0]  frame_cnt_q, frame_cnt_d;
  logic [5:0]  kills_q, kills_d;

  logic [9:0]         col_alive;
  logic [4:0]         row_alive;
  logic [3:0]         lmin, rmax;
  logic [2:0]         bmax;
  logic               col_neg;
  logic signed [10:0] col_s, right_px, left_px;
  logic [10:0]        bottom_px;
  logic [7:0]         period;
  logic [3:0]         kill_shift;
  logic [63:0]        grid_ext;
  logic               hit_ok;
  logic               step_now;

  // Live extents of the formation.
  always_comb begin
    col_alive = '0;
    row_alive = '0;
    for (int c = 0; c < 10; c++) begin
      for (int r = 0; r < 5; r++) begin
        col_alive[c] = col_alive[c] | grid_q[r*10 + c];
      end
    end
    for (int r = 0; r < 5; r++) begin
      row_alive[r] = |grid_q[r*10 +: 10];
    end
    lmin = 4'd0;
    for (int c = 9; c >= 0; c--) begin
      if (col_alive[c]) lmin = 4'(c);
    end
    rmax = 4'd0;
    for (int c = 0; c < 10; c++) begin
      if (col_alive[c]) rmax = 4'(c);
    end
    bmax = 3'd0;
    for (int r = 0; r < 5; r++) begin
      if (row_alive[r]) bmax = 3'(r);
    end
  end

  // Once the left columns are dead the origin legitimately marches past
  // pixel 0, so AliensCol is a two's-complement value. Any origin at or
  // beyond the right bound cannot occur on the right-hand side (the
  // rightmost alien would already be off screen), so such codes are the
  // negative offsets.
  assign col_neg   = (col_q >= 10'(RIGHT_LIMIT));
  assign col_s     = $signed({col_neg, col_q});
  // Right edge of the rightmost live column: 40*(rmax+1) - 10 = 40*rmax + 30.
  assign right_px  = col_s + $signed(11'(rmax) * 11'd40 + 11'd30);
  assign left_px   = col_s + $signed(11'(lmin) * 11'd40);
  // Bottom edge of the lowest live row: 30*(bmax+1) - 10 = 30*bmax + 20.
  assign bottom_px = 11'(row_q) + 11'(bmax) * 11'd30 + 11'd20;

  assign kill_shift = kills_q[5:2];
  assign period     = (BASE_P > {4'd0, kill_shift}) ? (BASE_P - {4'd0, kill_shift}) : 8'd1;

  assign grid_ext = {14'd0, grid_q};
  assign hit_ok   = HitValid && (HitIndex < 6'd50) && grid_ext[HitIndex];

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q      <= RUN;
      grid_q       <= '1;
      row_q        <= 9'(START_ROW);
      col_q        <= 10'(START_COL);
      dir_q        <= 1'b1;
      step_pulse_q <= 1'b0;
      bottom_q     <= 1'b0;
      defeated_q   <= 1'b0;
      frame_cnt_q  <= '0;
      kills_q      <= '0;
    end else begin
      state_q      <= state_d;
      grid_q       <= grid_d;
      row_q        <= row_d;
      col_q        <= col_d;
      dir_q        <= dir_d;
      step_pulse_q <= step_pulse_d;
      bottom_q     <= bottom_d;
      defeated_q   <= defeated_d;
      frame_cnt_q  <= frame_cnt_d;
      kills_q      <= kills_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    grid_d       = grid_q;
    row_d        = row_q;
    col_d        = col_q;
    dir_d        = dir_q;
    step_pulse_d = 1'b0;
    bottom_d     = bottom_q;
    defeated_d   = defeated_q;
    frame_cnt_d  = frame_cnt_q;
    kills_d      = kills_q;
    step_now     = 1'b0;

    unique case (state_q)
      RUN: begin
        if (FrameTick) begin
          // >= rather than == so a period that shrinks below the running
          // count still wraps on the next frame.
          if (frame_cnt_q >= period - 8'd1) begin
            frame_cnt_d = '0;
            // An empty grid has no extents; it is about to freeze anyway.
            step_now    = (grid_q != '0);
          end else begin
            frame_cnt_d = frame_cnt_q + 8'd1;
          end
        end

        if (step_now) begin
          step_pulse_d = 1'b1;
          if (dir_q) begin
            if (right_px + STEP_S > RIGHT_S) begin
              row_d = row_q + 9'(DROP_Y);
              dir_d = 1'b0;
            end else begin
              col_d = col_q + 10'(STEP_X);
            end
          end else begin
            if (left_px < LEFT_S) begin
              row_d = row_q + 9'(DROP_Y);
              dir_d = 1'b1;
            end else begin
              col_d = col_q - 10'(STEP_X);
            end
          end
        end

        if (hit_ok) begin
          grid_d  = grid_q & ~(50'd1 << HitIndex);
          kills_d = kills_q + 6'd1;
        end

        if (grid_q == '0) begin
          state_d    = CLEARED;
          defeated_d = 1'b1;
        end else if (bottom_px >= BOTTOM_U) begin
          state_d  = GAME_OVER;
          bottom_d = 1'b1;
        end
      end

      GAME_OVER: begin
      end

      CLEARED: begin
        if (NewWave) begin
          state_d     = RUN;
          grid_d      = '1;
          row_d       = 9'(START_ROW);
          col_d       = 10'(START_COL);
          dir_d       = 1'b1;
          bottom_d    = 1'b0;
          defeated_d  = 1'b0;
          frame_cnt_d = '0;
          kills_d     = '0;
        end
      end

      default: begin
        state_d = RUN;
      end
    endcase
  end

  assign Aliens_Grid     = grid_q;
  assign AliensRow       = row_q;
  assign AliensCol       = col_q;
  assign Dir             = dir_q;
  assign StepPulse       = step_pulse_q;
  assign Reached_Bottom  = bottom_q;
  assign Aliens_Defeated = defeated_q;

endmodule

// File: tb/tb_alien_formation_ctrl.sv
module tb_alien_formation_ctrl;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        FrameTick;
  logic        HitValid;
  logic [5:0]  HitIndex;
  logic        NewWave;

  logic [49:0] a_grid, b_grid;
  logic [8:0]  a_row, b_row;
  logic [9:0]  a_col, b_col;
  logic        a_dir, b_dir, a_pulse, b_pulse, a_bot, b_bot, a_def, b_def;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 Clk = ~Clk;

  alien_formation_ctrl u_dut (
    .Clk(Clk), .Reset(Reset), .FrameTick(FrameTick), .HitValid(HitValid),
    .HitIndex(HitIndex), .NewWave(NewWave),
    .Aliens_Grid(a_grid), .AliensRow(a_row), .AliensCol(a_col), .Dir(a_dir),
    .StepPulse(a_pulse), .Reached_Bottom(a_bot), .Aliens_Defeated(a_def)
  );

  alien_formation_ctrl #(.BASE_PERIOD(1), .BOTTOM_LIMIT(60)) u_dut_b (
    .Clk(Clk), .Reset(Reset), .FrameTick(FrameTick), .HitValid(HitValid),
    .HitIndex(HitIndex), .NewWave(NewWave),
    .Aliens_Grid(b_grid), .AliensRow(b_row), .AliensCol(b_col), .Dir(b_dir),
    .StepPulse(b_pulse), .Reached_Bottom(b_bot), .Aliens_Defeated(b_def)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic clk_step();
    @(posedge Clk);
    #1;
  endtask

  task automatic hit(input logic [5:0] idx);
    HitValid = 1'b1;
    HitIndex = idx;
    clk_step();
    HitValid = 1'b0;
    HitIndex = 6'd0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [49:0] full;
    logic [49:0] exp_grid;
    logic [9:0]  neg36;
    int pulses, misaligned, first_pulse;

    full  = '1;
    neg36 = 10'd988;   // -36 as a 10-bit two's-complement origin
    Reset = 1'b1; FrameTick = 1'b0; HitValid = 1'b0; HitIndex = 6'd0; NewWave = 1'b0;

    // Reset values
    clk_step();
    chk("rst_grid", 64'(a_grid), 64'(full));
    chk("rst_col", 64'(a_col), 64'd20);
    chk("rst_row", 64'(a_row), 64'd40);
    chk("rst_dir", 64'(a_dir), 64'd1);
    chk("rst_pulse", 64'(a_pulse), 64'd0);
    chk("rst_bottom", 64'(a_bot), 64'd0);
    chk("rst_defeated", 64'(a_def), 64'd0);
    chk("b_rst_bottom", 64'(b_bot), 64'd0);

    // March right with FrameTick every cycle
    Reset = 1'b0; FrameTick = 1'b1;
    pulses = 0; misaligned = 0;
    for (int k = 1; k <= 870; k++) begin
      clk_step();
      if (a_pulse) pulses++;
      if (a_pulse != ((k % 30) == 0)) misaligned++;
      if (k == 1) begin
        chk("b_bottom_asserted", 64'(b_bot), 64'd1);
        chk("b_col_first_step", 64'(b_col), 64'd28);
      end
      if (k == 840) begin
        chk("col_step28", 64'(a_col), 64'd244);
        chk("row_step28", 64'(a_row), 64'd40);
      end
    end
    chk("pulse_count_right", 64'(pulses), 64'd29);
    chk("pulse_alignment", 64'(misaligned), 64'd0);
    chk("row_after_drop", 64'(a_row), 64'd50);
    chk("dir_after_drop", 64'(a_dir), 64'd0);
    chk("col_after_drop", 64'(a_col), 64'd244);
    chk("b_frozen_col", 64'(b_col), 64'd28);
    chk("b_frozen_row", 64'(b_row), 64'd40);
    chk("b_still_bottom", 64'(b_bot), 64'd1);

    // Clear column 0
    FrameTick = 1'b0;
    exp_grid = full;
    for (int r = 0; r < 5; r++) begin
      hit(6'(r * 10));
      exp_grid[r*10] = 1'b0;
    end
    chk("grid_col0_cleared", 64'(a_grid), 64'(exp_grid));
    chk("b_ignores_hits", 64'(b_grid), 64'(full));

    // Out-of-range and repeated hits
    hit(6'd55);
    hit(6'd0);
    chk("grid_after_bad_hits", 64'(a_grid), 64'(exp_grid));

    // March left at period 29; drop only once origin+40 < 8
    FrameTick = 1'b1;
    pulses = 0; first_pulse = 0;
    for (int k = 1; k <= 36 * 29; k++) begin
      clk_step();
      if (a_pulse) begin
        pulses++;
        if (pulses == 1) first_pulse = k;
        if (pulses == 35) begin
          chk("col_step35_left", 64'(a_col), 64'(neg36));
          chk("dir_step35_left", 64'(a_dir), 64'd0);
        end
      end
    end
    chk("period_29", 64'(first_pulse), 64'd29);
    chk("pulse_count_left", 64'(pulses), 64'd36);
    chk("row_left_drop", 64'(a_row), 64'd60);
    chk("dir_left_drop", 64'(a_dir), 64'd1);
    chk("col_left_drop", 64'(a_col), 64'(neg36));

    // Kill the whole wave
    FrameTick = 1'b0;
    for (int i = 0; i < 50; i++) hit(6'(i));
    chk("grid_empty", 64'(a_grid), 64'd0);
    chk("defeated_not_yet", 64'(a_def), 64'd0);
    clk_step();
    chk("defeated_set", 64'(a_def), 64'd1);
    FrameTick = 1'b1;
    repeat (40) clk_step();
    chk("cleared_col_frozen", 64'(a_col), 64'(neg36));
    chk("cleared_row_frozen", 64'(a_row), 64'd60);
    chk("cleared_no_pulse", 64'(a_pulse), 64'd0);
    FrameTick = 1'b0;
    NewWave = 1'b1;
    clk_step();
    NewWave = 1'b0;
    chk("wave_grid", 64'(a_grid), 64'(full));
    chk("wave_col", 64'(a_col), 64'd20);
    chk("wave_row", 64'(a_row), 64'd40);
    chk("wave_dir", 64'(a_dir), 64'd1);
    chk("wave_defeated", 64'(a_def), 64'd0);

    // Reset collides with a step and a hit
    FrameTick = 1'b1;
    repeat (29) clk_step();
    chk("no_step_before_30", 64'(a_pulse), 64'd0);
    Reset = 1'b1; HitValid = 1'b1; HitIndex = 6'd5;
    clk_step();
    Reset = 1'b0; HitValid = 1'b0; HitIndex = 6'd0; FrameTick = 1'b0;
    chk("rst_win_grid", 64'(a_grid), 64'(full));
    chk("rst_win_col", 64'(a_col), 64'd20);
    chk("rst_win_pulse", 64'(a_pulse), 64'd0);
    clk_step();
    chk("rst_win_no_late_pulse", 64'(a_pulse), 64'd0);
    chk("rst_win_col_hold", 64'(a_col), 64'd20);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
